// File: rtl/rv32_dbg_pkg.sv
// rv32_dbg_pkg: shared widths and scan state encoding for the debug scanner
package rv32_dbg_pkg;
  localparam int DBG_ADDR_W = 7;
  localparam int DBG_DATA_W = 32;
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_STEP   = 3'd1,
    S_SETTLE = 3'd2,
    S_SET    = 3'd3,
    S_WAIT   = 3'd4,
    S_EMIT   = 3'd5,
    S_DONE   = 3'd6
  } scan_state_t;
endpackage

// File: rtl/dbg_wait_counter.sv
// dbg_wait_counter: loadable down-counter that parks at zero and flags it
module dbg_wait_counter #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic         zero_o
);
  logic [W-1:0] cnt_q;
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else if (load_i) cnt_q <= load_val_i;
    else if (cnt_q != '0) cnt_q <= cnt_q - 1'b1;
  end
  assign zero_o = cnt_q == '0;
endmodule

// File: rtl/rv32_debug_scanner.sv
// rv32_debug_scanner: optionally steps the core, then sweeps its debug registers into a valid/ready stream
module rv32_debug_scanner
  import rv32_dbg_pkg::*;
#(
  parameter int ADDR_W    = DBG_ADDR_W,
  parameter int DATA_W    = DBG_DATA_W,
  parameter int NUM_REGS  = 32,
  parameter int ADDR_WAIT = 2,
  parameter int SETTLE    = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              halt,
  input  logic              start,
  input  logic              do_step,
  input  logic              abort,
  output logic              debug_en,
  output logic              debug_step,
  output logic [ADDR_W-1:0] debug_addr,
  input  logic [DATA_W-1:0] debug_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_addr,
  output logic [DATA_W-1:0] out_data,
  output logic              busy,
  output logic              done
);
  localparam int MAX_CNT = SETTLE > ADDR_WAIT ? SETTLE : ADDR_WAIT;
  localparam int CNT_W = $clog2(MAX_CNT + 1);
  scan_state_t state_q, state_d;
  logic [ADDR_W:0] idx_q;
  logic [ADDR_W-1:0] debug_addr_q, out_addr_q;
  logic [DATA_W-1:0] out_data_q;
  logic debug_en_q, debug_step_q, out_valid_q, done_q;
  logic cnt_zero, cnt_load, last;
  logic [CNT_W-1:0] cnt_val;
  // the counter is loaded in the single cycle preceding each timed state
  assign cnt_load = state_q == S_STEP || state_q == S_SET;
  assign cnt_val = state_q == S_STEP ? CNT_W'(SETTLE - 1) : CNT_W'(ADDR_WAIT - 1);
  assign last = idx_q == (ADDR_W+1)'(NUM_REGS - 1);
  dbg_wait_counter #(.W(CNT_W)) u_cnt (
    .clk        (clk),
    .rst        (rst),
    .load_i     (cnt_load),
    .load_val_i (cnt_val),
    .zero_o     (cnt_zero)
  );
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   state_d = start ? (do_step ? S_STEP : S_SET) : S_IDLE;
      S_STEP:   state_d = S_SETTLE;
      S_SETTLE: state_d = cnt_zero ? S_SET : S_SETTLE;
      S_SET:    state_d = S_WAIT;
      S_WAIT:   state_d = cnt_zero ? S_EMIT : S_WAIT;
      S_EMIT:   state_d = out_ready ? (last ? S_DONE : S_SET) : S_EMIT;
      default:  state_d = S_IDLE;
    endcase
    if (abort) state_d = S_IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      idx_q        <= '0;
      debug_en_q   <= 1'b0;
      debug_step_q <= 1'b0;
      debug_addr_q <= '0;
      out_valid_q  <= 1'b0;
      out_addr_q   <= '0;
      out_data_q   <= '0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      debug_en_q   <= state_d != S_IDLE || halt;
      debug_step_q <= state_d == S_STEP;
      out_valid_q  <= state_d == S_EMIT;
      done_q       <= state_d == S_DONE;
      if (state_q == S_IDLE) idx_q <= '0;
      else if (state_q == S_EMIT && out_ready && !last) idx_q <= idx_q + 1'b1;
      if (state_q == S_SET && !abort) debug_addr_q <= idx_q[ADDR_W-1:0];
      if (state_q == S_WAIT && cnt_zero && !abort) begin
        out_addr_q <= idx_q[ADDR_W-1:0];
        out_data_q <= debug_data;
      end
    end
  end
  assign debug_en   = debug_en_q;
  assign debug_step = debug_step_q;
  assign debug_addr = debug_addr_q;
  assign out_valid  = out_valid_q;
  assign out_addr   = out_addr_q;
  assign out_data   = out_data_q;
  assign done       = done_q;
  assign busy       = state_q != S_IDLE;
endmodule

// File: tb/tb_rv32_debug_scanner.sv
// tb_rv32_debug_scanner: cycle-level schedule model of the scanner checked against the RTL every cycle
module tb_rv32_debug_scanner;
  localparam int AW = 2;
  localparam int ST = 4;
  localparam int N  = 32;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst = 1'b1, halt = 1'b0, start = 1'b0, do_step = 1'b0, abort = 1'b0, out_ready = 1'b0;
  logic debug_en, debug_step, out_valid, busy, done;
  logic [6:0] debug_addr, out_addr;
  logic [31:0] debug_data, out_data;
  logic start2 = 1'b0;
  logic debug_en2, debug_step2, out_valid2, busy2, done2;
  logic [6:0] debug_addr2, out_addr2;
  logic [31:0] debug_data2, out_data2;
  assign debug_data  = {25'h0, debug_addr} ^ 32'hA5A5_0000;
  assign debug_data2 = {25'h0, debug_addr2} ^ 32'hA5A5_0000;
  rv32_debug_scanner #(.ADDR_W(7), .DATA_W(32), .NUM_REGS(N), .ADDR_WAIT(AW), .SETTLE(ST)) dut (
    .clk(clk), .rst(rst), .halt(halt), .start(start), .do_step(do_step), .abort(abort),
    .debug_en(debug_en), .debug_step(debug_step), .debug_addr(debug_addr), .debug_data(debug_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_addr(out_addr), .out_data(out_data),
    .busy(busy), .done(done));
  rv32_debug_scanner #(.ADDR_W(7), .DATA_W(32), .NUM_REGS(128), .ADDR_WAIT(AW), .SETTLE(ST)) dut128 (
    .clk(clk), .rst(rst), .halt(1'b0), .start(start2), .do_step(1'b0), .abort(1'b0),
    .debug_en(debug_en2), .debug_step(debug_step2), .debug_addr(debug_addr2), .debug_data(debug_data2),
    .out_valid(out_valid2), .out_ready(1'b1), .out_addr(out_addr2), .out_data(out_data2),
    .busy(busy2), .done(done2));
  int n_tests = 0, n_fail = 0;
  bit m_busy = 0, m_valid = 0, m_done = 0, m_step = 0, m_en = 0;
  int m_wait = 0, m_idx = 0;
  logic [6:0] m_addr = '0, m_oaddr = '0;
  logic [31:0] m_odata = '0;
  logic [6:0] wa[$];
  logic [31:0] wd[$];
  int done_cnt = 0, step_cnt = 0, n2 = 0, done2_cnt = 0;
  logic [6:0] last2 = '0;
  bit rnd_ready = 0;
  function automatic logic [31:0] f(int i);
    return {25'h0, 7'(i)} ^ 32'hA5A5_0000;
  endfunction
  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask
  // a scan is a countdown to the next presented word; debug_addr moves AW cycles before it appears
  task automatic model_edge();
    if (rst) begin
      m_busy = 0; m_valid = 0; m_done = 0; m_step = 0; m_en = 0;
      m_wait = 0; m_idx = 0; m_addr = '0; m_oaddr = '0; m_odata = '0;
    end else begin
      m_step = 0;
      if (abort) begin
        m_busy = 0; m_valid = 0; m_done = 0; m_en = halt;
      end else if (!m_busy) begin
        m_done = 0; m_en = halt;
        if (start) begin
          m_busy = 1; m_en = 1; m_step = do_step; m_idx = 0;
          m_wait = (do_step ? 1 + ST : 0) + AW + 1;
        end
      end else if (m_done) begin
        m_busy = 0; m_done = 0; m_en = halt;
      end else if (m_valid) begin
        if (out_ready) begin
          m_valid = 0;
          if (m_idx == N - 1) m_done = 1;
          else begin m_idx++; m_wait = AW + 1; end
        end
      end else begin
        m_wait--;
        if (m_wait == AW) m_addr = 7'(m_idx);
        if (m_wait == 0) begin m_valid = 1; m_oaddr = 7'(m_idx); m_odata = f(m_idx); end
      end
    end
  endtask
  task automatic tick();
    if (out_valid && out_ready) begin wa.push_back(out_addr); wd.push_back(out_data); end
    if (out_valid2) begin n2++; last2 = out_addr2; end
    @(posedge clk);
    #1;
    model_edge();
    chk("debug_en", 64'(debug_en), 64'(m_en));
    chk("debug_step", 64'(debug_step), 64'(m_step));
    chk("busy", 64'(busy), 64'(m_busy));
    chk("done", 64'(done), 64'(m_done));
    chk("out_valid", 64'(out_valid), 64'(m_valid));
    chk("debug_addr", 64'(debug_addr), 64'(m_addr));
    chk("out_addr", 64'(out_addr), 64'(m_oaddr));
    chk("out_data", 64'(out_data), 64'(m_odata));
    if (done) done_cnt++;
    if (debug_step) step_cnt++;
    if (done2) done2_cnt++;
  endtask
  task automatic go(bit s);
    start = 1; do_step = s;
    tick();
    start = 0; do_step = 0;
  endtask
  task automatic run(int budget);
    int k = 0;
    while (busy && k < budget) begin
      out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      tick();
      k++;
    end
    chk("scan_timeout", 64'(busy), 64'(0));
  endtask
  initial begin
    int k, bad, lat;
    tick(); tick();
    rst = 0;
    tick();
    chk("reset_outputs", 64'({debug_en, debug_step, busy, done, out_valid}), 64'(0));
    // plain sweep, ready always high
    wa.delete(); wd.delete(); done_cnt = 0; step_cnt = 0; out_ready = 1;
    go(0); run(400);
    chk("s1_count", 64'(wa.size()), 64'(32));
    chk("s1_d0", 64'(wd[0]), 64'h0000_0000_A5A5_0000);
    chk("s1_d31", 64'(wd[31]), 64'h0000_0000_A5A5_001F);
    chk("s1_a31", 64'(wa[31]), 64'(31));
    chk("s1_done", 64'(done_cnt), 64'(1));
    chk("s1_nostep", 64'(step_cnt), 64'(0));
    // stepped sweep
    wa.delete(); wd.delete(); done_cnt = 0; step_cnt = 0; out_ready = 1;
    go(1);
    chk("s2_step_now", 64'(debug_step), 64'(1));
    lat = 1;
    while (!out_valid && lat < 50) begin tick(); lat++; end
    chk("s2_latency", 64'(lat), 64'(9));
    run(400);
    chk("s2_step_cnt", 64'(step_cnt), 64'(1));
    chk("s2_count", 64'(wa.size()), 64'(32));
    // random backpressure
    wa.delete(); wd.delete(); rnd_ready = 1;
    go(0); run(2000);
    rnd_ready = 0;
    bad = 0;
    foreach (wa[i]) if (wa[i] != 7'(i) || wd[i] != f(i)) bad++;
    chk("s3_count", 64'(wa.size()), 64'(32));
    chk("s3_order", 64'(bad), 64'(0));
    // abort while word 10 is stalled
    done_cnt = 0; out_ready = 1;
    go(0);
    k = 0;
    while (!(out_valid && out_addr == 7'd10) && k < 500) begin tick(); k++; end
    chk("s4_reach10", 64'({out_valid, out_addr}), 64'({1'b1, 7'd10}));
    out_ready = 0;
    tick(); tick();
    abort = 1; tick(); abort = 0;
    chk("s4_abort", 64'({busy, out_valid}), 64'(0));
    tick();
    chk("s4_nodone", 64'(done_cnt), 64'(0));
    wa.delete(); wd.delete(); out_ready = 1;
    go(0); run(400);
    chk("s4_restart_a0", 64'(wa[0]), 64'(0));
    chk("s4_restart_cnt", 64'(wa.size()), 64'(32));
    // reset mid-scan while word 5 is being waited on
    out_ready = 1;
    go(0);
    k = 0;
    while (debug_addr != 7'd5 && k < 300) begin tick(); k++; end
    rst = 1; tick(); rst = 0;
    chk("s5_rst_ctl", 64'({debug_en, debug_step, busy, done, out_valid}), 64'(0));
    chk("s5_rst_addr", 64'({debug_addr, out_addr}), 64'(0));
    chk("s5_rst_data", 64'(out_data), 64'(0));
    wa.delete(); wd.delete(); step_cnt = 0;
    go(0); tick();
    start = 1; do_step = 1; tick(); start = 0; do_step = 0;
    run(400);
    chk("s5_busy_start", 64'({32'(wa.size()), 32'(step_cnt)}), 64'({32'd32, 32'd0}));
    start = 1; abort = 1; tick(); start = 0; abort = 0;
    chk("s5_start_abort", 64'(busy), 64'(0));
    tick();
    chk("s5_still_idle", 64'(busy), 64'(0));
    // halt level and the full-range build
    halt = 1; tick();
    chk("s6_halt_en", 64'(debug_en), 64'(1));
    halt = 0; tick();
    chk("s6_unhalt_en", 64'(debug_en), 64'(0));
    n2 = 0; done2_cnt = 0;
    start2 = 1; tick(); start2 = 0;
    k = 0;
    while (busy2 && k < 2000) begin tick(); k++; end
    chk("s6_busy2", 64'(busy2), 64'(0));
    chk("s6_words128", 64'(n2), 64'(128));
    chk("s6_last7f", 64'(last2), 64'h7F);
    chk("s6_done2", 64'(done2_cnt), 64'(1));
    // random soak
    for (int c = 0; c < 6000; c++) begin
      int r;
      r = int'($urandom_range(0, 999));
      rst = r < 2;
      abort = r >= 2 && r < 8;
      start = $urandom_range(0, 24) == 0;
      do_step = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 49) == 0) halt = ~halt;
      out_ready = 1'($urandom_range(0, 1));
      tick();
    end
    rst = 0; abort = 0; start = 0; halt = 0; out_ready = 1;
    run(400);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
